fpu_result_queue: RTL and testbench

//  Downstream stage of the FPU wrapper: tracks issued ops through the fixed FPU latency, captures Result/flags

---
 rtl/fpu_result_queue.sv | 166 ++++++++++++++++
 tb/tb_fpu_result_queue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_queue.sv
// Result queue behind a fixed-latency FPU: tracks issued ops, captures results and flags in order,
// and gates issue with credits so the FIFO can never overflow.
module fpu_result_queue #(
  parameter int unsigned C_LATENCY = 2,
  parameter int unsigned C_DEPTH   = 4,
  parameter int unsigned C_TAG     = 5,
  parameter int unsigned C_OP      = 32
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             Issue_SI,
  input  logic [C_TAG-1:0] Tag_DI,
  output logic             Issue_Ready_SO,
  input  logic [C_OP-1:0]  Result_DI,
  input  logic             OF_SI,
  input  logic             UF_SI,
  input  logic             Zero_SI,
  input  logic             IX_SI,
  input  logic             IV_SI,
  input  logic             Inf_SI,
  output logic             Out_Valid_SO,
  input  logic             Out_Ready_SI,
  output logic [C_OP-1:0]  Out_Result_DO,
  output logic [C_TAG-1:0] Out_Tag_DO,
  output logic [5:0]       Out_Flags_DO,
  output logic [3:0]       FFlags_DO,
  input  logic             FFlagsClr_SI,
  output logic             Err_SO
);

  localparam int unsigned PtrW = $clog2(C_DEPTH);
  localparam int unsigned CntW = $clog2(C_DEPTH + 1);
  localparam int unsigned InfW = $clog2(C_LATENCY + 1);
  localparam int unsigned SumW = CntW + InfW;

  if (C_LATENCY < 1) begin : g_bad_latency
    $error("fpu_result_queue: C_LATENCY must be at least 1");
  end
  if ((C_DEPTH < 2) || ((C_DEPTH & (C_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fpu_result_queue: C_DEPTH must be a power of two >= 2");
  end

  // Latency tracker
  logic [C_LATENCY-1:0] trk_vld_q, trk_vld_d;
  logic [C_TAG-1:0]     trk_tag_q [C_LATENCY];
  logic [C_TAG-1:0]     trk_tag_d [C_LATENCY];
  logic [InfW-1:0]      inflight;
  logic                 issue_accept;

  // FIFO state
  logic [C_OP-1:0]  mem_res_q [C_DEPTH];
  logic [C_TAG-1:0] mem_tag_q [C_DEPTH];
  logic [5:0]       mem_flg_q [C_DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [SumW-1:0]  credit_used;
  logic             push, pop;
  logic [5:0]       flags_in;

  // Sticky state
  logic [3:0] fflags_q, fflags_d;
  logic       err_q, err_d;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < C_LATENCY; i++) begin
      inflight = inflight + InfW'(trk_vld_q[i]);
    end
  end

  // Credit depends on registered state only, so a pop frees credit one cycle later.
  assign credit_used    = SumW'(count_q) + SumW'(inflight);
  assign Issue_Ready_SO = (credit_used < SumW'(C_DEPTH));
  assign issue_accept   = Issue_SI & Issue_Ready_SO;

  always_comb begin
    trk_vld_d    = '0;
    trk_vld_d[0] = issue_accept;
    trk_tag_d[0] = Tag_DI;
    for (int unsigned i = 1; i < C_LATENCY; i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_tag_d[i] = trk_tag_q[i-1];
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      trk_vld_q <= '0;
      for (int unsigned i = 0; i < C_LATENCY; i++) begin
        trk_tag_q[i] <= '0;
      end
    end else begin
      trk_vld_q <= trk_vld_d;
      trk_tag_q <= trk_tag_d;
    end
  end

  assign flags_in     = {Inf_SI, IV_SI, IX_SI, Zero_SI, UF_SI, OF_SI};
  assign push         = trk_vld_q[C_LATENCY-1];
  assign Out_Valid_SO = (count_q != '0);
  assign pop          = Out_Valid_SO & Out_Ready_SI;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    fflags_d = FFlagsClr_SI ? 4'b0000 : fflags_q;
    if (push) begin
      fflags_d = fflags_d | {IV_SI, OF_SI, UF_SI, IX_SI};
    end
    err_d = err_q | (Issue_SI & ~Issue_Ready_SO);
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      fflags_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
      err_q    <= err_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      for (int unsigned i = 0; i < C_DEPTH; i++) begin
        mem_res_q[i] <= '0;
        mem_tag_q[i] <= '0;
        mem_flg_q[i] <= '0;
      end
    end else if (push) begin
      mem_res_q[wptr_q] <= Result_DI;
      mem_tag_q[wptr_q] <= trk_tag_q[C_LATENCY-1];
      mem_flg_q[wptr_q] <= flags_in;
    end
  end

  assign Out_Result_DO = mem_res_q[rptr_q];
  assign Out_Tag_DO    = mem_tag_q[rptr_q];
  assign Out_Flags_DO  = mem_flg_q[rptr_q];
  assign FFlags_DO     = fflags_q;
  assign Err_SO        = err_q;

endmodule

// File: tb/tb_fpu_result_queue.sv
// Bench for fpu_result_queue: acts as the FPU (delay line of results), keeps a credit model and an
// in-order scoreboard, and runs a hand-derived vector table plus multi-cycle corner sequences.
module tb_fpu_result_queue;

  localparam int unsigned L  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned TW = 5;
  localparam int unsigned OW = 32;

  logic          clk = 1'b0;
  logic          Rst_RI = 1'b1;
  logic          Issue_SI = 1'b0;
  logic [TW-1:0] Tag_DI = '0;
  logic          Issue_Ready_SO;
  logic [OW-1:0] Result_DI = '0;
  logic          OF_SI = 1'b0, UF_SI = 1'b0, Zero_SI = 1'b0;
  logic          IX_SI = 1'b0, IV_SI = 1'b0, Inf_SI = 1'b0;
  logic          Out_Valid_SO;
  logic          Out_Ready_SI = 1'b0;
  logic [OW-1:0] Out_Result_DO;
  logic [TW-1:0] Out_Tag_DO;
  logic [5:0]    Out_Flags_DO;
  logic [3:0]    FFlags_DO;
  logic          FFlagsClr_SI = 1'b0;
  logic          Err_SO;

  always #5 clk = ~clk;

  fpu_result_queue #(
    .C_LATENCY (L),
    .C_DEPTH   (D),
    .C_TAG     (TW),
    .C_OP      (OW)
  ) dut (
    .Clk_CI         (clk),
    .Rst_RI         (Rst_RI),
    .Issue_SI       (Issue_SI),
    .Tag_DI         (Tag_DI),
    .Issue_Ready_SO (Issue_Ready_SO),
    .Result_DI      (Result_DI),
    .OF_SI          (OF_SI),
    .UF_SI          (UF_SI),
    .Zero_SI        (Zero_SI),
    .IX_SI          (IX_SI),
    .IV_SI          (IV_SI),
    .Inf_SI         (Inf_SI),
    .Out_Valid_SO   (Out_Valid_SO),
    .Out_Ready_SI   (Out_Ready_SI),
    .Out_Result_DO  (Out_Result_DO),
    .Out_Tag_DO     (Out_Tag_DO),
    .Out_Flags_DO   (Out_Flags_DO),
    .FFlags_DO      (FFlags_DO),
    .FFlagsClr_SI   (FFlagsClr_SI),
    .Err_SO         (Err_SO)
  );

  typedef struct {
    bit            iss;
    logic [TW-1:0] tag;
    bit            ordy;
    bit            clr;
    logic [OW-1:0] res;
    logic [5:0]    flg;
    bit            e_rdy;
    bit            e_vld;
    logic [3:0]    e_ff;
    bit            e_err;
  } vec_t;

  typedef struct {
    logic [OW-1:0] res;
    logic [TW-1:0] tag;
    logic [5:0]    flg;
  } sb_t;

  vec_t tab[24];
  sb_t  sb[$];

  // FPU delay line: fd[0] holds the op presented last cycle
  logic [OW-1:0] fd_res [L];
  logic [5:0]    fd_flg [L];

  // Reference state
  int         m_count;
  bit         mv [L];
  logic [3:0] m_ff;
  bit         m_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_rdy();
    int inf = 0;
    for (int i = 0; i < int'(L); i++) inf += int'(mv[i]);
    return (m_count + inf) < int'(D);
  endfunction

  function automatic vec_t mk(bit iss, int tag, bit ordy, bit clr, logic [OW-1:0] res,
                              logic [5:0] flg, bit r, bit v, logic [3:0] ff, bit e);
    vec_t t;
    t.iss = iss; t.tag = TW'(tag); t.ordy = ordy; t.clr = clr; t.res = res; t.flg = flg;
    t.e_rdy = r; t.e_vld = v; t.e_ff = ff; t.e_err = e;
    return t;
  endfunction

  task automatic fpu_advance(input bit iss, input logic [OW-1:0] res, input logic [5:0] flg,
                             output logic [5:0] drv_flg);
    drv_flg   = fd_flg[L-1];
    Result_DI = fd_res[L-1];
    {Inf_SI, IV_SI, IX_SI, Zero_SI, UF_SI, OF_SI} = drv_flg;
    for (int i = int'(L) - 1; i > 0; i--) begin
      fd_res[i] = fd_res[i-1];
      fd_flg[i] = fd_flg[i-1];
    end
    fd_res[0] = iss ? res : OW'($urandom);
    fd_flg[0] = iss ? flg : 6'($urandom);
  endtask

  task automatic run_cycle(input bit iss, input logic [TW-1:0] tg, input bit ordy, input bit clr,
                           input logic [OW-1:0] res, input logic [5:0] flg, input bit use_tab,
                           input bit t_rdy, input bit t_vld, input logic [3:0] t_ff,
                           input bit t_err);
    logic [5:0] pf;
    bit         rdy_m, push, pop;
    sb_t        e;
    @(posedge clk);
    #1;
    Rst_RI       = 1'b0;
    Issue_SI     = iss;
    Tag_DI       = tg;
    Out_Ready_SI = ordy;
    FFlagsClr_SI = clr;
    fpu_advance(iss, res, flg, pf);
    rdy_m = model_rdy();
    @(negedge clk);
    chk("issue_ready", Issue_Ready_SO, use_tab ? t_rdy : rdy_m);
    chk("out_valid", Out_Valid_SO, use_tab ? t_vld : (m_count != 0));
    chk("fflags", FFlags_DO, use_tab ? t_ff : m_ff);
    chk("err", Err_SO, use_tab ? t_err : m_err);
    if (m_count != 0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: head valid in model but nothing expected (t=%0t)", $time);
      end else begin
        e = sb[0];
        chk("out_tag", Out_Tag_DO, e.tag);
        chk("out_result", Out_Result_DO, e.res);
        chk("out_flags", Out_Flags_DO, e.flg);
      end
    end
    if (Out_Valid_SO && ordy) n_pop++;
    // Advance the reference to the next registered state
    push = mv[L-1];
    pop  = (m_count != 0) && ordy;
    if (pop && sb.size() != 0) void'(sb.pop_front());
    if (iss && rdy_m) begin
      e.res = res; e.tag = tg; e.flg = flg;
      sb.push_back(e);
    end
    m_err = m_err | (iss && !rdy_m);
    if (clr) m_ff = 4'b0000;
    if (push) m_ff = m_ff | {pf[4], pf[0], pf[1], pf[3]};
    m_count = m_count + int'(push) - int'(pop);
    for (int i = int'(L) - 1; i > 0; i--) mv[i] = mv[i-1];
    mv[0] = iss && rdy_m;
  endtask

  task automatic cyc(input bit iss, input int tg, input bit ordy, input bit clr);
    run_cycle(iss, TW'(tg), ordy, clr, OW'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    logic [5:0] pf;
    @(posedge clk);
    #1;
    Rst_RI       = 1'b1;
    Issue_SI     = 1'b0;
    Out_Ready_SI = 1'b0;
    FFlagsClr_SI = 1'b0;
    fpu_advance(1'b0, '0, '0, pf);
    m_count = 0;
    for (int i = 0; i < int'(L); i++) mv[i] = 1'b0;
    m_ff  = 4'h0;
    m_err = 1'b0;
    sb.delete();
  endtask

  task automatic chk_reset_outputs();
    cyc(0, 0, 1, 0);
    chk("rst_out_result", Out_Result_DO, 0);
    chk("rst_out_tag", Out_Tag_DO, 0);
    chk("rst_out_flags", Out_Flags_DO, 0);
  endtask

  initial begin
    int p0;
    for (int i = 0; i < int'(L); i++) begin
      fd_res[i] = '0;
      fd_flg[i] = '0;
    end

    // T1 / T4 / T2 as hand-derived per-cycle vectors
    tab[0]  = mk(1,  3, 1, 0, 32'h3F80_0000, 6'b000000, 1, 0, 4'b0000, 0);
    tab[1]  = mk(0,  0, 1, 0, 32'h0,         6'b000000, 1, 0, 4'b0000, 0);
    tab[2]  = mk(0,  0, 1, 0, 32'h0,         6'b000000, 1, 0, 4'b0000, 0);
    tab[3]  = mk(0,  0, 1, 0, 32'h0,         6'b000000, 1, 1, 4'b0000, 0);
    tab[4]  = mk(0,  0, 1, 0, 32'h0,         6'b000000, 1, 0, 4'b0000, 0);
    tab[5]  = mk(1, 10, 1, 0, 32'h7FC0_0000, 6'b010000, 1, 0, 4'b0000, 0);
    tab[6]  = mk(1, 11, 1, 0, 32'h3EAA_AAAB, 6'b001000, 1, 0, 4'b0000, 0);
    tab[7]  = mk(1, 12, 1, 0, 32'h7F7F_FFFF, 6'b000001, 1, 0, 4'b0000, 0);
    tab[8]  = mk(0,  0, 1, 0, 32'h0,         6'b000000, 1, 1, 4'b1000, 0);
    tab[9]  = mk(0,  0, 1, 1, 32'h0,         6'b000000, 1, 1, 4'b1001, 0);
    tab[10] = mk(0,  0, 1, 0, 32'h0,         6'b000000, 1, 1, 4'b0100, 0);
    tab[11] = mk(0,  0, 1, 0, 32'h0,         6'b000000, 1, 0, 4'b0100, 0);
    tab[12] = mk(1, 20, 0, 0, 32'h4000_0000, 6'b000000, 1, 0, 4'b0100, 0);
    tab[13] = mk(1, 21, 0, 0, 32'h4000_0001, 6'b000000, 1, 0, 4'b0100, 0);
    tab[14] = mk(1, 22, 0, 0, 32'h4000_0002, 6'b000000, 1, 0, 4'b0100, 0);
    tab[15] = mk(1, 23, 0, 0, 32'h4000_0003, 6'b000000, 1, 1, 4'b0100, 0);
    tab[16] = mk(1, 24, 0, 0, 32'h4000_0004, 6'b000000, 0, 1, 4'b0100, 0);
    tab[17] = mk(0,  0, 0, 0, 32'h0,         6'b000000, 0, 1, 4'b0100, 1);
    tab[18] = mk(0,  0, 0, 0, 32'h0,         6'b000000, 0, 1, 4'b0100, 1);
    tab[19] = mk(0,  0, 1, 0, 32'h0,         6'b000000, 0, 1, 4'b0100, 1);
    tab[20] = mk(0,  0, 1, 0, 32'h0,         6'b000000, 1, 1, 4'b0100, 1);
    tab[21] = mk(0,  0, 1, 0, 32'h0,         6'b000000, 1, 1, 4'b0100, 1);
    tab[22] = mk(0,  0, 1, 0, 32'h0,         6'b000000, 1, 1, 4'b0100, 1);
    tab[23] = mk(0,  0, 1, 0, 32'h0,         6'b000000, 1, 0, 4'b0100, 1);

    do_reset();
    chk_reset_outputs();

    p0 = 0;
    foreach (tab[i]) begin
      if (i == 19) p0 = n_pop;
      run_cycle(tab[i].iss, tab[i].tag, tab[i].ordy, tab[i].clr, tab[i].res, tab[i].flg, 1'b1,
                tab[i].e_rdy, tab[i].e_vld, tab[i].e_ff, tab[i].e_err);
    end
    chk("t2_pop_count", n_pop - p0, 4);

    // T5: reset with one entry queued and two ops in flight
    cyc(1, 5, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 6, 0, 0);
    cyc(1, 7, 0, 0);
    do_reset();
    chk_reset_outputs();
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);

    // T3: ten back-to-back ops with a free-running consumer
    p0 = n_pop;
    for (int i = 0; i < 10; i++) cyc(1, i, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    chk("t3_pop_count", n_pop - p0, 10);
    chk("t3_no_drop", Err_SO, 0);

    // T6: full FIFO, pop and issue in the same cycle
    for (int i = 0; i < 4; i++) cyc(1, 16 + i, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 30, 1, 0);
    cyc(1, 31, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);

    // Random traffic against the reference
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
